// File: rtl/full_adder.sv
// Registered ripple-carry adder: a + b + cin -> {cout, s}, with signed overflow.
// One-cycle latency. Every output comes straight from a flop, so no
// combinational path runs from any input to any output.
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid
);

   // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_comb;
   logic             ovf_comb;

   logic [WIDTH-1:0] s_d, s_q;
   logic             cout_d, cout_q;
   logic             ovf_d, ovf_q;
   logic             out_valid_d, out_valid_q;

   assign carry[0] = cin;

   // One classic 1-bit full-adder cell per bit, chained through carry
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_cell
         assign sum_comb[gi]  = a[gi] ^ b[gi] ^ carry[gi];
         assign carry[gi+1]   = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
      end
   endgenerate

   // Signed overflow: the carry into the MSB disagrees with the carry out.
   // At WIDTH=1 the carry into the MSB is cin itself.
   assign ovf_comb = carry[WIDTH-1] ^ carry[WIDTH];

   // Next state: load a fresh result on a valid strobe, otherwise hold.
   // With in_valid low the mux never selects the adder, so X/Z operands are ignored.
   always_comb begin
      s_d         = s_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         s_d         = sum_comb;
         cout_d      = carry[WIDTH];
         ovf_d       = ovf_comb;
         out_valid_d = 1'b1;
      end
   end

   // Result registers. Reset clears them immediately and drops any in-flight input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q         <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         s_q         <= s_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1 and WIDTH=8.
// The stimulus pushes the expected results, and a monitor per instance checks them.
module tb_full_adder;

   typedef struct packed {
      logic [7:0] s;
      logic       cout;
      logic       ovf;
      int         due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   // WIDTH=1 instance signals
   logic       v1, a1, b1, c1;
   logic       s1, cout1, ovf1, ov1;
   // WIDTH=8 instance signals
   logic       v8, c8;
   logic [7:0] a8, b8, s8;
   logic       cout8, ovf8, ov8;

   exp_t q1[$];
   exp_t q8[$];

   full_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
      .s(s1), .cout(cout1), .ovf(ovf1), .out_valid(ov1)
   );

   full_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
      .s(s8), .cout(cout8), .ovf(ovf8), .out_valid(ov8)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog: the run must never hang
   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, simulation did not finish (got hang, want finish)");
      $fatal(1, "watchdog");
   end

   // Monitor for the WIDTH=1 instance
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (ov1) begin
            n_checks++;
            if (q1.size() == 0) begin
               n_fail++;
               $display("FAIL w1_unexpected: out_valid=1 s=%0d cout=%0d with no result pending", s1, cout1);
            end else begin
               e = q1.pop_front();
               if (s1 !== e.s[0] || cout1 !== e.cout || ovf1 !== e.ovf || cyc != e.due) begin
                  n_fail++;
                  $display("FAIL w1_result: got s=%0d cout=%0d ovf=%0d cyc=%0d, want s=%0d cout=%0d ovf=%0d cyc=%0d",
                           s1, cout1, ovf1, cyc, e.s[0], e.cout, e.ovf, e.due);
               end else
                  $display("w1 ok: s=%0d cout=%0d ovf=%0d", s1, cout1, ovf1);
            end
         end else if (q1.size() > 0 && q1[0].due <= cyc) begin
            n_checks++;
            n_fail++;
            e = q1.pop_front();
            $display("FAIL w1_missing: out_valid=0 at cyc %0d, want result due at cyc %0d", cyc, e.due);
         end
      end
   end

   // Monitor for the WIDTH=8 instance
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (ov8) begin
            n_checks++;
            if (q8.size() == 0) begin
               n_fail++;
               $display("FAIL w8_unexpected: out_valid=1 s=%02h cout=%0d with no result pending", s8, cout8);
            end else begin
               e = q8.pop_front();
               if (s8 !== e.s || cout8 !== e.cout || ovf8 !== e.ovf || cyc != e.due) begin
                  n_fail++;
                  $display("FAIL w8_result: got s=%02h cout=%0d ovf=%0d cyc=%0d, want s=%02h cout=%0d ovf=%0d cyc=%0d",
                           s8, cout8, ovf8, cyc, e.s, e.cout, e.ovf, e.due);
               end
            end
         end else if (q8.size() > 0 && q8[0].due <= cyc) begin
            n_checks++;
            n_fail++;
            e = q8.pop_front();
            $display("FAIL w8_missing: out_valid=0 at cyc %0d, want result due at cyc %0d", cyc, e.due);
         end
      end
   end

   // Drive one valid WIDTH=1 vector and register its hand-computed result
   task automatic issue1(input logic a, input logic b, input logic c,
                         input logic es, input logic ec, input logic eo);
      exp_t e;
      a1 = a; b1 = b; c1 = c; v1 = 1'b1;
      e.s = {7'd0, es}; e.cout = ec; e.ovf = eo; e.due = cyc + 1;
      q1.push_back(e);
      @(posedge clk); #1;
   endtask

   // Drive one valid WIDTH=8 vector with its expected result
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo);
      exp_t e;
      a8 = a; b8 = b; c8 = c; v8 = 1'b1;
      e.s = es; e.cout = ec; e.ovf = eo; e.due = cyc + 1;
      q8.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      v1 = 1'b0; v8 = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic check_direct(input string name, input logic [9:0] got, input logic [9:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %03h, want %03h", name, got, want);
      end else
         $display("%s ok: %03h", name, got);
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rc;
      logic [8:0] full;
      logic       rovf;

      rst_n = 1'b0;
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
      #1;
      // Reset state, no clock edge seen yet: {out_valid, ovf, cout, s}
      check_direct("reset_w1", {6'd0, ov1, ovf1, cout1, s1}, 10'h000);
      check_direct("reset_w8", {ov8, ovf8, cout8, s8}, 10'h000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // WIDTH=1 truth table, back to back: a, b, cin -> s, cout, ovf
      issue1(0, 0, 0, 0, 0, 0);
      issue1(1, 0, 0, 1, 0, 0);
      issue1(0, 1, 0, 1, 0, 0);
      issue1(0, 0, 1, 1, 0, 1);
      issue1(1, 1, 0, 0, 1, 1);
      issue1(1, 0, 1, 0, 1, 0);
      issue1(0, 1, 1, 0, 1, 0);
      issue1(1, 1, 1, 1, 1, 0);

      // Hold: operands change with in_valid low, so 1+1+1 stays registered
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      @(posedge clk); #1;
      check_direct("hold_w1", {6'd0, ov1, ovf1, cout1, s1}, 10'h003);

      // Asynchronous reset between edges clears the outputs before the next edge
      #2;
      rst_n = 1'b0;
      #1;
      check_direct("async_rst_w1", {6'd0, ov1, ovf1, cout1, s1}, 10'h000);
      // This vector is presented while reset is held, so it must be discarded
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
      @(posedge clk); #1;
      check_direct("rst_discard_w1", {6'd0, ov1, ovf1, cout1, s1}, 10'h000);
      q1.delete();
      rst_n = 1'b1;
      // The first valid edge after release produces a result
      issue1(1, 0, 0, 1, 0, 0);
      idle(2);

      // WIDTH=8 directed wrap and signed overflow cases
      issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      issue8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
      issue8(8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0);
      idle(2);

      // Throughput: 1000 random back-to-back vectors. The expected result
      // comes from integer addition plus a sign-based overflow rule.
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         rovf = (ra[7] == rb[7]) && (full[7] != ra[7]);
         issue8(ra, rb, rc, full[7:0], full[8], rovf);
      end
      idle(3);

      // Every issued result must have been consumed
      check_direct("drain_w1", 10'(q1.size()), 10'h000);
      check_direct("drain_w8", 10'(q8.size()), 10'h000);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
